// File: rtl/sdram_arbiter_if.sv
// Host, engine request/enable/fin and latched-address signals of the SDRAM arbiter.
// The oerror wire exists only when SDRAM_ARB_TIMEOUT_EN is defined.
interface sdram_arbiter_if;
    logic        ihost_rd_req;
    logic        ihost_wr_req;
    logic [24:0] ihost_addr;
    logic        ohost_busy;
    logic        ohost_done;
    logic        oready;
    logic [12:0] orow;
    logic [9:0]  ocolumn;
    logic [1:0]  obank;
    logic        oinit_req;
    logic        orefresh_req;
    logic        oread_req;
    logic        owrite_req;
    logic        oinit_enb;
    logic        orefresh_enb;
    logic        oread_enb;
    logic        owrite_enb;
    logic        iinit_fin;
    logic        irefresh_fin;
    logic        iread_fin;
    logic        iwrite_fin;
`ifdef SDRAM_ARB_TIMEOUT_EN
    logic        oerror;
`endif

    // master: the arbiter itself; slave: host plus the four engines
`ifdef SDRAM_ARB_TIMEOUT_EN
    modport master (
        input  ihost_rd_req, ihost_wr_req, ihost_addr,
        input  iinit_fin, irefresh_fin, iread_fin, iwrite_fin,
        output ohost_busy, ohost_done, oready, orow, ocolumn, obank,
        output oinit_req, orefresh_req, oread_req, owrite_req,
        output oinit_enb, orefresh_enb, oread_enb, owrite_enb,
        output oerror
    );
    modport slave (
        output ihost_rd_req, ihost_wr_req, ihost_addr,
        output iinit_fin, irefresh_fin, iread_fin, iwrite_fin,
        input  ohost_busy, ohost_done, oready, orow, ocolumn, obank,
        input  oinit_req, orefresh_req, oread_req, owrite_req,
        input  oinit_enb, orefresh_enb, oread_enb, owrite_enb,
        input  oerror
    );
`else
    modport master (
        input  ihost_rd_req, ihost_wr_req, ihost_addr,
        input  iinit_fin, irefresh_fin, iread_fin, iwrite_fin,
        output ohost_busy, ohost_done, oready, orow, ocolumn, obank,
        output oinit_req, orefresh_req, oread_req, owrite_req,
        output oinit_enb, orefresh_enb, oread_enb, owrite_enb
    );
    modport slave (
        output ihost_rd_req, ihost_wr_req, ihost_addr,
        output iinit_fin, irefresh_fin, iread_fin, iwrite_fin,
        input  ohost_busy, ohost_done, oready, orow, ocolumn, obank,
        input  oinit_req, orefresh_req, oread_req, owrite_req,
        input  oinit_enb, orefresh_enb, oread_enb, owrite_enb
    );
`endif
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM bus sequencer: power-up init, periodic auto-refresh, single host reads/writes.
// Optional WAIT-state watchdog and sticky oerror enabled by defining SDRAM_ARB_TIMEOUT_EN.
//
// state       | meaning
// S_RST       | held in reset; first edge after release enters S_INIT_REQ
// S_INIT_REQ  | init engine start pulse
// S_INIT_WAIT | init engine owns the bus until iinit_fin
// S_IDLE      | no engine enabled; accept refresh or host request
// S_REF_REQ   | refresh start pulse; refresh counter and pending cleared
// S_REF_WAIT  | refresh engine owns the bus until irefresh_fin
// S_RD_REQ    | read start pulse
// S_RD_WAIT   | read engine owns the bus until iread_fin
// S_WR_REQ    | write start pulse
// S_WR_WAIT   | write engine owns the bus until iwrite_fin
module sdram_arbiter #(
    parameter int REFRESH_INTERVAL = 780,
    parameter int REF_CTR_WIDTH    = 11
) (
    input  logic          iclk,
    input  logic          ireset,
    sdram_arbiter_if.master bus
);

    typedef enum logic [8:0] {
        S_RST       = 9'b000000000,
        S_INIT_REQ  = 9'b000000001,
        S_INIT_WAIT = 9'b000000010,
        S_IDLE      = 9'b000000100,
        S_REF_REQ   = 9'b000001000,
        S_REF_WAIT  = 9'b000010000,
        S_RD_REQ    = 9'b000100000,
        S_RD_WAIT   = 9'b001000000,
        S_WR_REQ    = 9'b010000000,
        S_WR_WAIT   = 9'b100000000
    } state_t;

    localparam logic [REF_CTR_WIDTH-1:0] REF_LAST = REF_CTR_WIDTH'(REFRESH_INTERVAL - 1);

    state_t                   state_q, state_d;
    logic [REF_CTR_WIDTH-1:0] ref_cnt_q, ref_cnt_d;
    logic                     pending_q, pending_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [24:0]              addr_q, addr_d;
    logic                     init_req_q, init_req_d, init_enb_q, init_enb_d;
    logic                     ref_req_q, ref_req_d, ref_enb_q, ref_enb_d;
    logic                     rd_req_q, rd_req_d, rd_enb_q, rd_enb_d;
    logic                     wr_req_q, wr_req_d, wr_enb_q, wr_enb_d;
    logic                     fin_match;
    logic                     timeout;

    // Only the fin of the engine currently being waited on is looked at.
    always_comb begin
        fin_match = ((state_q == S_INIT_WAIT) && bus.iinit_fin)
                  | ((state_q == S_REF_WAIT)  && bus.irefresh_fin)
                  | ((state_q == S_RD_WAIT)   && bus.iread_fin)
                  | ((state_q == S_WR_WAIT)   && bus.iwrite_fin);
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic       in_wait;
    logic [5:0] wd_q, wd_d;
    logic       err_q, err_d;

    // wd_q is 0 in the first WAIT cycle, so expiry at 62 means 63 cycles spent waiting.
    always_comb begin
        in_wait = (state_q == S_INIT_WAIT) || (state_q == S_REF_WAIT)
               || (state_q == S_RD_WAIT)   || (state_q == S_WR_WAIT);
        wd_d    = in_wait ? (wd_q + 6'd1) : 6'd0;
        timeout = in_wait && (wd_q == 6'd62);
        err_d   = err_q | (timeout & ~fin_match);
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            wd_q  <= 6'd0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign bus.oerror = err_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        unique case (state_q)
            S_RST:       state_d = S_INIT_REQ;
            S_INIT_REQ:  state_d = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (fin_match) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else if (timeout) begin
                    state_d = S_INIT_REQ;
                end
            end
            S_IDLE: begin
                if (pending_q) begin
                    state_d = S_REF_REQ;
                end else if (!busy_q && bus.ihost_wr_req) begin
                    state_d = S_WR_REQ;
                    addr_d  = bus.ihost_addr;
                end else if (!busy_q && bus.ihost_rd_req) begin
                    state_d = S_RD_REQ;
                    addr_d  = bus.ihost_addr;
                end
            end
            S_REF_REQ:   state_d = S_REF_WAIT;
            S_REF_WAIT: begin
                if (fin_match || timeout) state_d = S_IDLE;
            end
            S_RD_REQ:    state_d = S_RD_WAIT;
            S_WR_REQ:    state_d = S_WR_WAIT;
            S_RD_WAIT, S_WR_WAIT: begin
                if (fin_match || timeout) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:     state_d = S_RST;
        endcase
    end

    // Saturating interval counter; pending latches at the last count until REF_REQ.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        pending_d = pending_q;
        if (state_q == S_REF_REQ) begin
            ref_cnt_d = '0;
            pending_d = 1'b0;
        end else begin
            if (ready_q && (ref_cnt_q != REF_LAST)) ref_cnt_d = ref_cnt_q + REF_CTR_WIDTH'(1);
            if (ref_cnt_d == REF_LAST) pending_d = 1'b1;
        end
    end

    always_comb begin
        busy_d     = (state_d != S_IDLE) | pending_d | ~ready_d;
        init_req_d = (state_d == S_INIT_REQ);
        init_enb_d = (state_d == S_INIT_REQ) || (state_d == S_INIT_WAIT);
        ref_req_d  = (state_d == S_REF_REQ);
        ref_enb_d  = (state_d == S_REF_REQ)  || (state_d == S_REF_WAIT);
        rd_req_d   = (state_d == S_RD_REQ);
        rd_enb_d   = (state_d == S_RD_REQ)   || (state_d == S_RD_WAIT);
        wr_req_d   = (state_d == S_WR_REQ);
        wr_enb_d   = (state_d == S_WR_REQ)   || (state_d == S_WR_WAIT);
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q    <= S_RST;
            ref_cnt_q  <= '0;
            pending_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            addr_q     <= '0;
            init_req_q <= 1'b0;
            init_enb_q <= 1'b0;
            ref_req_q  <= 1'b0;
            ref_enb_q  <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_enb_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_enb_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_cnt_q  <= ref_cnt_d;
            pending_q  <= pending_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            init_req_q <= init_req_d;
            init_enb_q <= init_enb_d;
            ref_req_q  <= ref_req_d;
            ref_enb_q  <= ref_enb_d;
            rd_req_q   <= rd_req_d;
            rd_enb_q   <= rd_enb_d;
            wr_req_q   <= wr_req_d;
            wr_enb_q   <= wr_enb_d;
        end
    end

    assign bus.ohost_busy   = busy_q;
    assign bus.ohost_done   = done_q;
    assign bus.oready       = ready_q;
    assign bus.obank        = addr_q[24:23];
    assign bus.orow         = addr_q[22:10];
    assign bus.ocolumn      = addr_q[9:0];
    assign bus.oinit_req    = init_req_q;
    assign bus.oinit_enb    = init_enb_q;
    assign bus.orefresh_req = ref_req_q;
    assign bus.orefresh_enb = ref_enb_q;
    assign bus.oread_req    = rd_req_q;
    assign bus.oread_enb    = rd_enb_q;
    assign bus.owrite_req   = wr_req_q;
    assign bus.owrite_enb   = wr_enb_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed plus randomized bench for sdram_arbiter against a bus-ownership reference model.
module tb_sdram_arbiter;
    localparam int RI = 16;
    localparam int O_RST = 0, O_INIT = 1, O_REF = 2, O_RD = 3, O_WR = 4, O_IDLE = 5;

    logic iclk = 1'b0;
    logic ireset;
    always #5 iclk = ~iclk;

    sdram_arbiter_if bus ();
    sdram_arbiter #(.REFRESH_INTERVAL(RI), .REF_CTR_WIDTH(11)) dut (
        .iclk(iclk), .ireset(ireset), .bus(bus));

    int n_checks = 0, n_fail = 0;
    int n_init = 0, n_ref = 0, n_done = 0;

    // Model: which engine owns the bus, whether this is its start cycle, and the
    // edge at which the refresh interval last restarted (pending derived from elapsed edges).
    int          m_own, m_wt, m_base, m_edge = 0;
    bit          m_first, m_ready, m_done, m_err;
    logic [24:0] m_addr;

    function automatic bit m_pend(input int e);
        return m_ready && ((e - m_base) >= RI - 1);
    endfunction

    function automatic bit m_busy(input int e);
        return (m_own != O_IDLE) || m_pend(e) || !m_ready;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, m_edge);
        end
    endtask

    task automatic model_reset();
        m_own = O_RST; m_first = 0; m_ready = 0; m_done = 0; m_err = 0;
        m_addr = '0; m_wt = 0; m_base = 0;
    endtask

    task automatic compare();
        chk("init_req", bus.oinit_req,    (m_own == O_INIT) && m_first);
        chk("init_enb", bus.oinit_enb,    m_own == O_INIT);
        chk("ref_req",  bus.orefresh_req, (m_own == O_REF) && m_first);
        chk("ref_enb",  bus.orefresh_enb, m_own == O_REF);
        chk("rd_req",   bus.oread_req,    (m_own == O_RD) && m_first);
        chk("rd_enb",   bus.oread_enb,    m_own == O_RD);
        chk("wr_req",   bus.owrite_req,   (m_own == O_WR) && m_first);
        chk("wr_enb",   bus.owrite_enb,   m_own == O_WR);
        chk("busy",     bus.ohost_busy,   m_busy(m_edge));
        chk("done",     bus.ohost_done,   m_done);
        chk("ready",    bus.oready,       m_ready);
        chk("bank",     bus.obank,        m_addr[24:23]);
        chk("row",      bus.orow,         m_addr[22:10]);
        chk("column",   bus.ocolumn,      m_addr[9:0]);
`ifdef SDRAM_ARB_TIMEOUT_EN
        chk("error",    bus.oerror,       m_err);
`endif
        if (bus.oinit_req === 1'b1)    n_init++;
        if (bus.orefresh_req === 1'b1) n_ref++;
        if (bus.ohost_done === 1'b1)   n_done++;
    endtask

    task automatic predict(input bit rd, input bit wr, input logic [24:0] a, input logic [3:0] fin);
        bit pc, bc;
        pc = m_pend(m_edge);
        bc = m_busy(m_edge);
        m_done = 1'b0;
        if (m_own == O_RST) begin
            m_own = O_INIT; m_first = 1;
        end else if (m_own == O_IDLE) begin
            if (pc) begin
                m_own = O_REF; m_first = 1;
            end else if (!bc && wr) begin
                m_own = O_WR; m_first = 1; m_addr = a;
            end else if (!bc && rd) begin
                m_own = O_RD; m_first = 1; m_addr = a;
            end
        end else if (m_first) begin
            m_first = 0; m_wt = 1;
            if (m_own == O_REF) m_base = m_edge + 1;
        end else if (fin[m_own-1]) begin
            if (m_own == O_INIT) begin m_ready = 1; m_base = m_edge + 1; end
            m_done = (m_own == O_RD) || (m_own == O_WR);
            m_own = O_IDLE;
        end else begin
`ifdef SDRAM_ARB_TIMEOUT_EN
            if (m_wt == 63) begin
                m_err = 1;
                if (m_own == O_INIT) m_first = 1;
                else begin
                    m_done = (m_own == O_RD) || (m_own == O_WR);
                    m_own = O_IDLE;
                end
            end else begin
                m_wt = m_wt + 1;
            end
`else
            m_wt = m_wt + 1;
`endif
        end
        m_edge++;
    endtask

    // fin bits: [0]=init [1]=refresh [2]=read [3]=write; called #1 after a rising edge.
    task automatic cycle(input bit rd, input bit wr, input logic [24:0] a, input logic [3:0] fin);
        bus.ihost_rd_req = rd;
        bus.ihost_wr_req = wr;
        bus.ihost_addr   = a;
        bus.iinit_fin    = fin[0];
        bus.irefresh_fin = fin[1];
        bus.iread_fin    = fin[2];
        bus.iwrite_fin   = fin[3];
        predict(rd, wr, a, fin);
        @(posedge iclk); #1;
        compare();
    endtask

    function automatic logic [3:0] auto_fin();
        logic [3:0] f = 4'b0;
        if (m_own >= O_INIT && m_own <= O_WR && !m_first && m_wt >= 3) f[m_own-1] = 1'b1;
        return f;
    endfunction

    task automatic settle();
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (m_own == O_IDLE && !m_busy(m_edge)) ok = 1;
            else cycle(0, 0, '0, auto_fin());
        end
        n_checks++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL settle_bound observed=not_idle expected=idle edge=%0d", m_edge);
        end
    endtask

    task automatic reset_mid();
        #3 ireset = 1'b1;
        #1;
        chk("rst_init_enb", bus.oinit_enb, 0);
        chk("rst_ref_enb",  bus.orefresh_enb, 0);
        chk("rst_rd_enb",   bus.oread_enb, 0);
        chk("rst_wr_enb",   bus.owrite_enb, 0);
        chk("rst_busy",     bus.ohost_busy, 1);
        chk("rst_ready",    bus.oready, 0);
        model_reset();
        @(posedge iclk); #1;
        ireset = 1'b0;
        compare();
    endtask

    initial begin
        int d_before, r_before;
        ireset = 1'b1;
        bus.ihost_rd_req = 0; bus.ihost_wr_req = 0; bus.ihost_addr = '0;
        bus.iinit_fin = 0; bus.irefresh_fin = 0; bus.iread_fin = 0; bus.iwrite_fin = 0;
        model_reset();
        repeat (2) @(posedge iclk);
        #1;
        ireset = 1'b0;
        compare();

        // Power-up init, fin 20 cycles after the start pulse
        cycle(0, 0, '0, 4'b0);
        repeat (19) cycle(0, 0, '0, 4'b0);
        cycle(0, 0, '0, 4'b0001);
        chk("init_pulses", n_init, 1);
        chk("ready_after_init", bus.oready, 1);
        chk("busy_after_init", bus.ohost_busy, 0);

        // Write with known address, fin held two cycles
        cycle(0, 1, {2'b10, 13'h1ABC, 10'h155}, 4'b0);
        chk("wr_req_dir", bus.owrite_req, 1);
        chk("bank_dir", bus.obank, 2);
        chk("row_dir", bus.orow, 13'h1ABC);
        chk("col_dir", bus.ocolumn, 10'h155);
        cycle(0, 0, '0, 4'b0);
        cycle(0, 0, '0, 4'b1000);
        chk("wr_done_dir", bus.ohost_done, 1);
        chk("wr_enb_off", bus.owrite_enb, 0);
        cycle(0, 0, '0, 4'b1000);
        chk("wr_done_once", bus.ohost_done, 0);
        settle();

        // Simultaneous read and write: write wins, read dropped
        d_before = n_done;
        cycle(1, 1, 25'h0ABCDEF, 4'b0);
        chk("both_wr", bus.owrite_req, 1);
        chk("both_rd", bus.oread_req, 0);
        settle();
        chk("both_one_done", n_done - d_before, 1);

        // Idle: periodic refresh
        r_before = n_ref;
        for (int i = 0; i < 60; i++) cycle(0, 0, '0, auto_fin());
        chk("refresh_periodic", (n_ref - r_before) >= 2, 1);

        // Refresh falls due during a long read; host pulses meanwhile are dropped
        settle();
        cycle(1, 0, 25'h1555AAA, 4'b0);
        for (int i = 0; i < 29; i++) cycle(1'($urandom()), 1'($urandom()), 25'($urandom()), 4'b0);
        cycle(0, 0, '0, 4'b0100);
        chk("long_rd_done", bus.ohost_done, 1);
        chk("long_rd_busy", bus.ohost_busy, 1);
        cycle(1, 1, 25'h0000123, 4'b0);
        chk("ref_after_rd", bus.orefresh_req, 1);
        settle();

        // Randomized traffic with random (often stray) fin pulses
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] f;
            for (int b = 0; b < 4; b++) f[b] = ($urandom_range(0, 4) == 0);
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, 25'($urandom()), f);
        end
        settle();

        // Reset while a read is outstanding, then init again
        cycle(1, 0, 25'h1FFFFFF, 4'b0);
        cycle(0, 0, '0, 4'b0);
        cycle(0, 0, '0, 4'b0);
        chk("rd_enb_before_rst", bus.oread_enb, 1);
        reset_mid();
        n_init = 0;
        for (int i = 0; i < 6; i++) cycle(0, 0, '0, 4'b0);
        cycle(0, 0, '0, 4'b0001);
        chk("reinit_pulses", n_init, 1);
        chk("reinit_ready", bus.oready, 1);
        settle();

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Watchdog: read never finishes, then init never finishes
        cycle(1, 0, 25'h0123456, 4'b0);
        for (int i = 0; i < 70; i++) cycle(0, 0, '0, 4'b0);
        chk("timeout_error", bus.oerror, 1);
        settle();
        reset_mid();
        chk("error_cleared", bus.oerror, 0);
        for (int i = 0; i < 70; i++) cycle(0, 0, '0, 4'b0);
        chk("init_timeout_ready", bus.oready, 0);
        settle();
        chk("init_after_timeout", bus.oready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Top-level sequencer for the SDRAM subsystem. It owns the shared SDRAM pin bus and grants it to exactly one engine at a time: init, refresh, read or write.
- Each engine gets a one-cycle request pulse and a level bus enable, and reports completion on its fin input.
- Runs power-up init once, then serves single host read/write transactions, inserting auto-refresh at a fixed interval with priority over host traffic.

Parameters:
- REFRESH_INTERVAL, 780: cycles between refresh requests (7.8 us at 100 MHz).
- REF_CTR_WIDTH, 11: width of the refresh interval counter; must hold REFRESH_INTERVAL.

Ports:
- iclk  in  1  system clock; also drives the SDRAM clock via the engines.
- ireset  in  1  asynchronous, active-high reset.
- ihost_rd_req  in  1  one-cycle read request pulse; honoured only while ohost_busy=0.
- ihost_wr_req  in  1  one-cycle write request pulse; honoured only while ohost_busy=0.
- ihost_addr  in  25  {bank[24:23], row[22:10], column[9:0]}; sampled with the request.
- ohost_busy  out  1  arbiter cannot accept a host request.
- ohost_done  out  1  one-cycle pulse when a host transaction completes.
- oready  out  1  init complete; stays high until reset.
- orow  out  13  latched row, to the read and write engines.
- ocolumn  out  10  latched column, to the read and write engines.
- obank  out  2  latched bank, to the read and write engines.
- oinit_req, orefresh_req, oread_req, owrite_req  out  1 each  engine start pulses.
- oinit_enb, orefresh_enb, oread_enb, owrite_enb  out  1 each  engine bus enables; at most one is high.
- iinit_fin, irefresh_fin, iread_fin, iwrite_fin  in  1 each  engine completion flags; may stay high for more than one cycle.

Behaviour:
- Reset values:
  - all *_req=0 and all *_enb=0, asynchronously on ireset.
  - ohost_busy=1, ohost_done=0, oready=0.
  - orow, ocolumn, obank = 0.
  - refresh counter = 0, refresh_pending=0.
- Reset mid-operation: all enables drop immediately; the FSM restarts at INIT_REQ after reset is released.
- Output timing: all outputs are registered. Each *_enb is high in that engine's REQ and WAIT states. Each *_req is high only in the REQ state.
- FSM is one-hot with these states:
  - INIT_REQ: oinit_req=1, oinit_enb=1 for one cycle; go to INIT_WAIT.
  - INIT_WAIT: hold oinit_enb=1 until iinit_fin=1. Then set oready=1, go to IDLE.
  - IDLE (all enables low):
    - refresh_pending=1: go to REF_REQ.
    - Else write pulse (takes priority over read): go to WR_REQ.
    - Else read pulse: go to RD_REQ.
    - Else stay in IDLE.
  - REF_REQ: one cycle; clear refresh_pending and the counter; go to REF_WAIT.
  - REF_WAIT: on irefresh_fin=1, go to IDLE.
  - RD_REQ or WR_REQ: one cycle; go to the matching WAIT state.
  - RD_WAIT or WR_WAIT: on the matching fin=1, go to IDLE and pulse ohost_done for one cycle.
- fin inputs are examined only in the matching WAIT state. A fin still high after leaving WAIT is ignored, as is any fin from an engine that is not enabled.
- Address capture: on an accepted host pulse, {obank, orow, ocolumn} <= ihost_addr, updated in the same edge as entry to the REQ state.
- Host request acceptance:
  - Both request pulses in the same cycle: the write is served and the read is dropped.
  - Pulses while ohost_busy=1 are dropped.
- ohost_busy = (next state != IDLE) | refresh_pending | ~oready, registered. It falls in the same cycle ohost_done rises.
- Latency: a pulse at edge N gives *_req=1 at N+1. fin sampled at edge M gives ohost_done=1 and ohost_busy=0 at M+1.
- Refresh counter:
  - Counts only while oready=1 and saturates at REFRESH_INTERVAL-1.
  - On reaching REFRESH_INTERVAL-1, refresh_pending is set and stays set until REF_REQ.
  - A refresh due during a host transaction waits for that transaction to finish, then is issued directly from IDLE.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - A 6-bit watchdog clears on entry to any WAIT state and increments each cycle in that state.
  - At count 63 without fin: drop the enable, go to IDLE, and set sticky output oerror (1 bit, reset 0, cleared only by ireset).
  - If the timed-out state was RD_WAIT or WR_WAIT, ohost_done is still pulsed.
  - A timeout in INIT_WAIT goes to INIT_REQ instead, leaving oready=0.
- Undefined: no watchdog; WAIT states wait indefinitely; oerror port absent.

Test Plan:
- Reset, iinit_fin raised 20 cycles after oinit_req -> exactly one oinit_req pulse; oready=1 and ohost_busy=0 one cycle after fin; no other enable ever high.
- Idle, ihost_wr_req pulse with ihost_addr={2'b10,13'h1ABC,10'h155} -> next cycle owrite_req=1, owrite_enb=1, obank=2, orow=0x1ABC, ocolumn=0x155; iwrite_fin held 2 cycles -> single ohost_done pulse, owrite_enb low after the first fin cycle.
- Read and write pulses in the same cycle -> write served; read dropped; one ohost_done.
- REFRESH_INTERVAL=16, no host traffic -> orefresh_req every 16+refresh-duration cycles; ohost_busy=1 from pending until irefresh_fin+1.
- Refresh falls due during a 30-cycle read -> read completes, then orefresh_req the cycle after IDLE is entered; host pulses during this window are dropped.
- ireset asserted in RD_WAIT -> oread_enb=0 immediately; after release the init sequence repeats; with SDRAM_ARB_TIMEOUT_EN defined and fin withheld -> enable drops after 63 WAIT cycles and oerror=1.
